// File: rtl/pattern_pkg.sv
// Shared definitions for the multi-channel serial pattern detector.
package pattern_pkg;

  localparam int PAT_W_MAX = 32;

  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pattern_chan.sv
// One detector channel: shift history, fill tracking, match/prefix flags and a
// saturating match counter. All outputs decode from this channel's registers.
module pattern_chan
  import pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             pat_wr,
  input  logic             clr_cnt,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             y,
  output logic             z,
  output logic             t,
  output logic [CNT_W-1:0] cnt
);

  localparam int FILL_W = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;
  logic              match_p1;
  logic              prefix;
  logic [PAT_W-1:0]  mask;

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FULL) ? f : f + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    fill_inc = sat_fill(fill);
    hit      = 1'b0;
    if (pat_wr) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (en) begin
      hist_nxt = {hist[PAT_W-2:0], a};
      hit      = (fill_inc == FULL) && (hist_nxt == pattern);
      // Non-overlapping mode forgets the whole matched window.
      fill_nxt = (hit && !overlap) ? '0 : fill_inc;
    end
  end

  // Stage p1: registered history, fill, match pulse and counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist     <= '0;
      fill     <= '0;
      match_p1 <= 1'b0;
      cnt      <= '0;
    end else begin
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      match_p1 <= hit;
      if (clr_cnt)
        cnt <= hit ? CNT_W'(1) : '0;
      else if (hit)
        cnt <= sat_cnt(cnt);
    end
  end

  // Newest k history bits against the first k pattern bits, k limited by fill.
  always_comb begin
    prefix = 1'b0;
    mask   = '0;
    for (int k = 1; k < PAT_W; k++) begin
      mask = {PAT_W{1'b1}} >> (PAT_W - k);
      if ((FILL_W'(k) <= fill) && (((hist ^ (pattern >> (PAT_W - k))) & mask) == '0))
        prefix = 1'b1;
    end
  end

  assign y = match_p1;
  assign z = prefix && !match_p1;
  assign t = (cnt == CNT_MAX);

endmodule

// File: rtl/pattern_detector_multi.sv
// Multi-channel serial pattern detector: shared run-time loadable pattern
// register feeding one independent detector channel per serial input.
module pattern_detector_multi
  import pattern_pkg::*;
#(
  parameter int          CHANNELS = 2,
  parameter int          PAT_W    = 4,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] PAT_INIT = 32'hB
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       A,
  input  logic                      pat_wr,
  input  logic [PAT_W-1:0]          pat_in,
  input  logic                      overlap,
  input  logic                      clr_cnt,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS-1:0]       t,
  output logic [CHANNELS*CNT_W-1:0] cnt
);

  logic [PAT_W-1:0] pattern;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pattern <= PAT_INIT[PAT_W-1:0];
    else if (pat_wr)
      pattern <= pat_in;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pattern_chan #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .a       (A[c]),
      .pat_wr  (pat_wr),
      .clr_cnt (clr_cnt),
      .overlap (overlap),
      .pattern (pattern),
      .y       (y[c]),
      .z       (z[c]),
      .t       (t[c]),
      .cnt     (cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule
